// File: rtl/idop_pkg.sv
// Shared types and constants for the matrix identity-update engine.
package idop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_ADD_BIT  = 0;
    localparam int MODE_DIAG_BIT = 1;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic logic [63:0] idop_one(input int frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/idop_addsub.sv
// Single-element add/subtract of lambda; saturating when IDOP_SATURATE_EN is defined,
// two's-complement wrap-around otherwise.
module idop_addsub #(
    parameter int nBits = 32
) (
    input  logic [nBits-1:0] operand,
    input  logic [nBits-1:0] lambda,
    input  logic             add,
    output logic [nBits-1:0] result,
    output logic             overflow
);

`ifdef IDOP_SATURATE_EN
    logic [nBits:0] wide;

    always_comb begin
        wide = add ? ({operand[nBits-1], operand} + {lambda[nBits-1], lambda})
                   : ({operand[nBits-1], operand} - {lambda[nBits-1], lambda});
        // Sign bit and guard bit disagree exactly when the true sum left the range.
        overflow = wide[nBits] ^ wide[nBits-1];
        if (!overflow)
            result = wide[nBits-1:0];
        else if (wide[nBits])
            result = {1'b1, {(nBits-1){1'b0}}};
        else
            result = {1'b0, {(nBits-1){1'b1}}};
    end
`else
    always_comb begin
        result   = add ? (operand + lambda) : (operand - lambda);
        overflow = 1'b0;
    end
`endif

endmodule

// File: rtl/matrix_identity_update.sv
// Adds or subtracts lambda*I (full diagonal or one element) to an M x N fixed-point matrix.
// Optional saturation is enabled by defining IDOP_SATURATE_EN.
module matrix_identity_update
    import idop_pkg::*;
#(
    parameter int M     = 2,
    parameter int N     = 1,
    parameter int nBits = 32,
    parameter int FRAC  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [nBits-1:0]     lambda,
    input  logic [nBits-1:0]     position,
    input  logic [nBits-1:0]     col,
    input  logic [M*N*nBits-1:0] a,
    output logic [M*N*nBits-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 ovf
);

    localparam int DMAX = (M < N) ? M : N;
    localparam int KW   = $clog2(DMAX + 1);
    localparam int EW   = (M * N > 1) ? $clog2(M * N) : 1;

    generate
        if (FRAC < 0 || FRAC >= nBits) begin : g_bad_frac
            $error("FRAC must lie in [0, nBits)");
        end
    endgenerate

    state_t               state;
    logic [nBits-1:0]     work     [M*N];
    logic [nBits-1:0]     work_nxt [M*N];
    logic [M*N*nBits-1:0] work_flat;
    logic [nBits-1:0]     lambda_q;
    logic [1:0]           mode_q;
    logic [EW-1:0]        tgt_idx;
    logic [EW-1:0]        cur_idx;
    logic [KW-1:0]        k;
    logic                 last;
    logic                 in_range;
    logic [nBits-1:0]     sum;
    logic                 sum_ovf;

    assign in_range = (position < nBits'(M)) && (col < nBits'(N));

    // Diagonal element (k,k) sits at flat index k*N + k.
    always_comb begin
        cur_idx = tgt_idx;
        last    = 1'b1;
        if (mode_q[MODE_DIAG_BIT]) begin
            cur_idx = EW'(int'(k) * (N + 1));
            last    = (int'(k) == DMAX - 1);
        end
    end

    idop_addsub #(.nBits(nBits)) u_addsub (
        .operand  (work[cur_idx]),
        .lambda   (lambda_q),
        .add      (mode_q[MODE_ADD_BIT]),
        .result   (sum),
        .overflow (sum_ovf)
    );

    always_comb begin
        work_nxt = work;
        if (state == WALK)
            work_nxt[cur_idx] = sum;
    end

    always_comb begin
        work_flat = '0;
        for (int e = 0; e < M * N; e++)
            work_flat[e*nBits +: nBits] = work_nxt[e];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            b        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
            k        <= '0;
            lambda_q <= '0;
            mode_q   <= '0;
            tgt_idx  <= '0;
            // NOTE: the work register is a small flop array, so clearing it on reset is cheap and keeps b deterministic.
            for (int e = 0; e < M * N; e++)
                work[e] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int e = 0; e < M * N; e++)
                            work[e] <= a[e*nBits +: nBits];
                        lambda_q <= lambda;
                        mode_q   <= mode;
                        tgt_idx  <= EW'(position * nBits'(N) + col);
                        k        <= '0;
                        err      <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        if (!mode[MODE_DIAG_BIT] && !in_range) begin
                            err   <= 1'b1;
                            b     <= a;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= WALK;
                        end
                    end
                end
                WALK: begin
                    work <= work_nxt;
                    ovf  <= ovf | sum_ovf;
                    k    <= k + 1'b1;
                    if (last) begin
                        b     <= work_flat;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_identity_update.sv
// Scoreboard bench for matrix_identity_update: a 2x1 instance for most scenarios, a 2x2 one for full-diagonal walks.
module tb_matrix_identity_update;
    import idop_pkg::*;

    typedef struct {
        logic [127:0] b;
        logic         err;
        logic         ovf;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2x1 instance
    logic        rst1 = 1'b1, start1 = 1'b0;
    logic [1:0]  mode1 = '0;
    logic [31:0] lambda1 = '0, pos1 = '0, col1 = '0;
    logic [63:0] a1 = '0, b1;
    logic        busy1, done1, err1, ovf1;

    // 2x2 instance
    logic         rst2 = 1'b1, start2 = 1'b0;
    logic [1:0]   mode2 = '0;
    logic [31:0]  lambda2 = '0, pos2 = '0, col2 = '0;
    logic [127:0] a2 = '0, b2;
    logic         busy2, done2, err2, ovf2;

    matrix_identity_update #(.M(2), .N(1), .nBits(32), .FRAC(15)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .mode(mode1), .lambda(lambda1),
        .position(pos1), .col(col1), .a(a1), .b(b1), .busy(busy1), .done(done1),
        .err(err1), .ovf(ovf1)
    );

    matrix_identity_update #(.M(2), .N(2), .nBits(32), .FRAC(15)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .mode(mode2), .lambda(lambda2),
        .position(pos2), .col(col2), .a(a2), .b(b2), .busy(busy2), .done(done2),
        .err(err2), .ovf(ovf2)
    );

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] lam,
                                          input bit add, output bit ov);
        longint s;
        s  = add ? (longint'($signed(x)) + longint'($signed(lam)))
                 : (longint'($signed(x)) - longint'($signed(lam)));
        ov = 1'b0;
`ifdef IDOP_SATURATE_EN
        if (s > 64'sd2147483647) begin ov = 1'b1; return 32'h7FFF_FFFF; end
        if (s < -64'sd2147483648) begin ov = 1'b1; return 32'h8000_0000; end
`endif
        return s[31:0];
    endfunction

    // Drives one request into the 2x1 instance and returns the cycle (relative to the accept edge)
    // where done was seen; inputs are scrambled after the accept edge since they are don't-care.
    task automatic run1(input logic [63:0] av, input logic [31:0] lam, input logic [1:0] md,
                        input logic [31:0] ps, input logic [31:0] cl,
                        output int lat, output logic busy_at1);
        @(negedge clk);
        a1 = av; lambda1 = lam; mode1 = md; pos1 = ps; col1 = cl; start1 = 1'b1;
        lat = -1;
        busy_at1 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start1 = 1'b0;
                busy_at1 = busy1;
                a1 = {$urandom, $urandom}; lambda1 = $urandom; mode1 = 2'($urandom);
                pos1 = $urandom; col1 = $urandom;
            end
            if (done1 === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({b1, busy1, done1, err1, ovf1} !== 68'd0) begin
            n_bad++;
            $display("FAIL reset_dut1: got b=%h busy=%b done=%b err=%b ovf=%b want all zero",
                     b1, busy1, done1, err1, ovf1);
        end
        n_cmp++;
        if ({b2, busy2, done2, err2, ovf2} !== 132'd0) begin
            n_bad++;
            $display("FAIL reset_dut2: got b=%h busy=%b done=%b want all zero", b2, busy2, done2);
        end
        rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_single;
        logic [63:0] av   [3] = '{64'h00020000_00010000, 64'h00020000_00010000, 64'h00020000_00010000};
        logic [31:0] ps   [3] = '{32'd0, 32'd1, 32'd0};
        logic [1:0]  md   [3] = '{2'b00, 2'b00, 2'b11};
        logic [63:0] bexp [3] = '{64'h00020000_00008000, 64'h00018000_00010000, 64'h00020000_00018000};
        int lat;
        logic busy_at1;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{b: {64'd0, bexp[i]}, err: 1'b0, ovf: 1'b0, lat: 2});
            run1(av[i], 32'h0000_8000, md[i], ps[i], 32'd0, lat, busy_at1);
            e = sb.pop_front();
            n_cmp++;
            if (b1 !== e.b[63:0]) begin
                n_bad++;
                $display("FAIL single%0d_b: got %h want %h", i, b1, e.b[63:0]);
            end
            n_cmp++;
            if (lat !== e.lat || err1 !== e.err || busy_at1 !== 1'b1) begin
                n_bad++;
                $display("FAIL single%0d_ctl: got lat=%0d err=%b busy=%b want lat=%0d err=%b busy=1",
                         i, lat, err1, busy_at1, e.lat, e.err);
            end
        end
    endtask

    task automatic test_range_error;
        logic [31:0] ps [2] = '{32'd2, 32'd0};
        logic [31:0] cl [2] = '{32'd0, 32'd1};
        logic [63:0] av;
        int lat;
        logic busy_at1;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            av = {$urandom, $urandom};
            sb.push_back('{b: {64'd0, av}, err: 1'b1, ovf: 1'b0, lat: 1});
            run1(av, 32'h0000_8000, 2'b00, ps[i], cl[i], lat, busy_at1);
            e = sb.pop_front();
            n_cmp++;
            if (b1 !== e.b[63:0] || err1 !== e.err) begin
                n_bad++;
                $display("FAIL range%0d: got b=%h err=%b want b=%h err=1", i, b1, err1, e.b[63:0]);
            end
            n_cmp++;
            if (lat !== e.lat) begin
                n_bad++;
                $display("FAIL range%0d_lat: got %0d want %0d", i, lat, e.lat);
            end
        end
    endtask

    task automatic test_overflow;
        logic [63:0] one64;
        logic [31:0] one;
        int lat;
        logic busy_at1;
        exp_t e;
        one64 = idop_one(15);
        one   = one64[31:0];
`ifdef IDOP_SATURATE_EN
        sb.push_back('{b: {64'd0, 64'h00010000_7FFFFFFF}, err: 1'b0, ovf: 1'b1, lat: 2});
`else
        sb.push_back('{b: {64'd0, 64'h00010000_80007FFF}, err: 1'b0, ovf: 1'b0, lat: 2});
`endif
        run1(64'h00010000_7FFFFFFF, one, 2'b01, 32'd0, 32'd0, lat, busy_at1);
        e = sb.pop_front();
        n_cmp++;
        if (b1 !== e.b[63:0] || ovf1 !== e.ovf) begin
            n_bad++;
            $display("FAIL overflow: got b=%h ovf=%b want b=%h ovf=%b", b1, ovf1, e.b[63:0], e.ovf);
        end
        // A clean follow-up operation must clear ovf.
        sb.push_back('{b: {64'd0, 64'h00010000_00018000}, err: 1'b0, ovf: 1'b0, lat: 2});
        run1(64'h00010000_00010000, one, 2'b01, 32'd0, 32'd0, lat, busy_at1);
        e = sb.pop_front();
        n_cmp++;
        if (b1 !== e.b[63:0] || ovf1 !== e.ovf) begin
            n_bad++;
            $display("FAIL ovf_clear: got b=%h ovf=%b want b=%h ovf=0", b1, ovf1, e.b[63:0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] av, bexp;
        logic [31:0] lam, ps, cl, el;
        logic [1:0]  md;
        bit ov;
        int idx, lat;
        logic busy_at1;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            av  = {$urandom, $urandom};
            lam = $urandom;
            md  = 2'($urandom);
            ps  = 32'($urandom_range(0, 2));
            cl  = 32'($urandom_range(0, 1));
            if (!md[1] && (ps > 1 || cl > 0)) begin
                sb.push_back('{b: {64'd0, av}, err: 1'b1, ovf: 1'b0, lat: 1});
            end else begin
                idx  = md[1] ? 0 : int'(ps);
                bexp = av;
                el   = av[idx*32 +: 32];
                bexp[idx*32 +: 32] = model(el, lam, md[0], ov);
                sb.push_back('{b: {64'd0, bexp}, err: 1'b0, ovf: ov, lat: 2});
            end
            run1(av, lam, md, ps, cl, lat, busy_at1);
            e = sb.pop_front();
            n_cmp++;
            if (b1 !== e.b[63:0] || err1 !== e.err || ovf1 !== e.ovf || lat !== e.lat) begin
                n_bad++;
                $display("FAIL b2b%0d: got b=%h err=%b ovf=%b lat=%0d want b=%h err=%b ovf=%b lat=%0d",
                         i, b1, err1, ovf1, lat, e.b[63:0], e.err, e.ovf, e.lat);
            end
        end
    endtask

    task automatic test_start_while_busy;
        int dones = 0, first = -1;
        @(negedge clk);
        a1 = 64'h00020000_00010000; lambda1 = 32'h0000_8000; mode1 = 2'b00;
        pos1 = 32'd0; col1 = 32'd0; start1 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 3) start1 = 1'b0;
            if (done1 === 1'b1) begin
                dones++;
                if (first < 0) first = n;
            end
        end
        n_cmp++;
        if (dones !== 1 || first !== 2) begin
            n_bad++;
            $display("FAIL start_busy: got dones=%0d first=%0d want dones=1 first=2", dones, first);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || b1 !== 64'h00020000_00008000) begin
            n_bad++;
            $display("FAIL start_busy_end: got busy=%b b=%h want busy=0 b=0002000000008000", busy1, b1);
        end
    endtask

    task automatic start_dut2(input logic [127:0] av, input logic [31:0] lam, input logic [1:0] md);
        @(negedge clk);
        a2 = av; lambda2 = lam; mode2 = md; pos2 = 32'd0; col2 = 32'd0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        a2 = {$urandom, $urandom, $urandom, $urandom}; lambda2 = $urandom;
    endtask

    task automatic test_full_diag;
        int lat = -1;
        exp_t e;
        sb.push_back('{b: 128'h00014000_00008000_00008000_00024000, err: 1'b0, ovf: 1'b0, lat: 3});
        start_dut2(128'h00010000_00008000_00008000_00020000, 32'h0000_4000, 2'b11);
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (done2 === 1'b1) begin
                lat = n;
                break;
            end
        end
        e = sb.pop_front();
        n_cmp++;
        if (b2 !== e.b) begin
            n_bad++;
            $display("FAIL full_diag_b: got %h want %h", b2, e.b);
        end
        n_cmp++;
        if (lat !== e.lat || err2 !== e.err || busy2 !== 1'b1) begin
            n_bad++;
            $display("FAIL full_diag_ctl: got lat=%0d err=%b busy=%b want lat=%0d err=0 busy=1",
                     lat, err2, busy2, e.lat);
        end
    endtask

    task automatic test_reset_mid_walk;
        int dones = 0;
        start_dut2(128'h00010000_00008000_00008000_00020000, 32'h0000_4000, 2'b11);
        rst2 = 1'b1;
        @(negedge clk);
        if (done2 === 1'b1) dones++;
        n_cmp++;
        if (b2 !== 128'd0 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_walk: got b=%h busy=%b want b=0 busy=0", b2, busy2);
        end
        rst2 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done2 === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0 || b2 !== 128'd0) begin
            n_bad++;
            $display("FAIL rst_walk_nodone: got dones=%0d b=%h want dones=0 b=0", dones, b2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_range_error();
        test_overflow();
        test_back_to_back();
        test_start_while_busy();
        test_full_diag();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
